// File: rtl/add_share_arb.sv
// Round-robin front end that time-shares one start/valid adder among NREQ requesters, tagging results by requester.
// Latency: best case 4 cycles per op (grant, start pulse, adder answer, response handshake); one op in flight.
// Backpressure: req_ready is granted only in IDLE; a held response (rsp_ready=0) blocks all new grants.
module add_share_arb #(
    parameter int W       = 16,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 8,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              add_start,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W-1:0]      add_y,
    input  logic              add_valid,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_y,
    input  logic              rsp_ready,
    output logic              err_to,
    output logic              err_sticky
);

    // Watchdog counter only needs to reach TIMEOUT-1.
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gid;
    logic [WDW-1:0]  wd_cnt;

    logic            grant_vld;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  scan_id;

    // Requester index successor, wrapping at NREQ (NREQ need not be a power of two).
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
        logic [IDW-1:0] nxt;
        if (v == IDW'(NREQ - 1)) begin
            nxt = '0;
        end else begin
            nxt = v + IDW'(1);
        end
        return nxt;
    endfunction

    // Round-robin scan starting at rr_ptr; the first pending requester found wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_id   = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_vld && req_valid[scan_id]) begin
                grant_vld = 1'b1;
                grant_id  = scan_id;
            end
            scan_id = wrap_inc(scan_id);
        end
    end

    // One-hot accept, only while idle; held at zero while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == S_IDLE) && grant_vld) begin
            req_ready = NREQ'(1) << grant_id;
        end
    end

    // Abort strobe is visible in the last watchdog cycle itself; a late answer in that cycle still wins.
    always_comb begin
        err_to = (state == S_WAIT) && !add_valid && (wd_cnt == WD_LAST);
    end

    // Sequencer: grant, pulse the adder, wait (with watchdog), hold the response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            gid        <= '0;
            wd_cnt     <= '0;
            add_start  <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_y      <= '0;
            err_sticky <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        add_a     <= req_a[grant_id*W +: W];
                        add_b     <= req_b[grant_id*W +: W];
                        gid       <= grant_id;
                        add_start <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    add_start <= 1'b0;
                    wd_cnt    <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (add_valid) begin
                        rsp_y     <= add_y;
                        rsp_id    <= gid;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (wd_cnt == WD_LAST) begin
                        // Adder never answered: drop the op and move fairness past the owner.
                        err_sticky <= 1'b1;
                        rr_ptr     <= wrap_inc(gid);
                        state      <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WDW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= wrap_inc(gid);
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_share_arb.sv
// Directed bench for add_share_arb with a behavioural adder of configurable latency.
// Latency: outputs sampled on the falling edge, inputs driven on the falling edge.
// Backpressure: rsp_ready is held low for several cycles in one step to exercise response hold.
module tb_add_share_arb;

    localparam int W    = 16;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              add_start;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic [W-1:0]      add_y;
    logic              add_valid;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_y;
    logic              rsp_ready;
    logic              err_to;
    logic              err_sticky;

    int n_cmp = 0;
    int n_err = 0;

    // Adder model controls.
    int          adder_lat  = 1;
    bit          adder_dead = 1'b0;
    int          mcnt;
    logic [W-1:0] msum;

    add_share_arb #(.W(W), .NREQ(NREQ), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .add_start  (add_start),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_y      (add_y),
        .add_valid  (add_valid),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_ready  (rsp_ready),
        .err_to     (err_to),
        .err_sticky (err_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared adder: answers adder_lat cycles after the cycle in which add_start is high.
    initial begin
        add_valid = 1'b0;
        add_y     = '0;
        mcnt      = 0;
        msum      = '0;
        forever begin
            @(posedge clk);
            #1;
            add_valid = 1'b0;
            if (mcnt > 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0 && !adder_dead) begin
                    add_valid = 1'b1;
                    add_y     = msum;
                end
            end
            if (add_start) begin
                mcnt = adder_lat;
                msum = add_a + add_b;
            end
        end
    end

    // Hard stop in case the sequence itself wedges.
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // One full operation, entered at a falling edge with the DUT idle and inputs already set.
    task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] y, input bit drop, input string tag);
        #1;
        chk({tag, ".grant"}, 32'(req_ready), 32'(1) << id);
        @(negedge clk);
        chk({tag, ".start"}, 32'(add_start), 32'd1);
        chk({tag, ".add_a"}, 32'(add_a), 32'(a));
        chk({tag, ".add_b"}, 32'(add_b), 32'(b));
        chk({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
        if (drop) req_valid[id] = 1'b0;
        @(negedge clk);
        chk({tag, ".start_once"}, 32'(add_start), 32'd0);
        for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(id));
        chk({tag, ".rsp_y"}, 32'(rsp_y), 32'(y));
        @(negedge clk);
        chk({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, ".add_start"}, 32'(add_start), 32'd0);
        chk({tag, ".add_a"}, 32'(add_a), 32'd0);
        chk({tag, ".add_b"}, 32'(add_b), 32'd0);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, ".rsp_y"}, 32'(rsp_y), 32'd0);
        chk({tag, ".err_to"}, 32'(err_to), 32'd0);
        chk({tag, ".err_sticky"}, 32'(err_sticky), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset state, with requests pending to show req_ready stays low.
        @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        @(negedge clk);

        // Fairness: all four pending, responses taken at once.
        set_op(0, 16'h1000, 16'h0011);
        set_op(1, 16'h2001, 16'h0022);
        set_op(2, 16'h3002, 16'h0033);
        set_op(3, 16'h4003, 16'h0044);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        run_op(0, 16'h1000, 16'h0011, 16'h1011, 1'b0, "fair0");
        run_op(1, 16'h2001, 16'h0022, 16'h2023, 1'b0, "fair1");
        run_op(2, 16'h3002, 16'h0033, 16'h3035, 1'b0, "fair2");
        run_op(3, 16'h4003, 16'h0044, 16'h4047, 1'b0, "fair3");
        run_op(0, 16'h1000, 16'h0011, 16'h1011, 1'b0, "fair4");
        run_op(1, 16'h2001, 16'h0022, 16'h2023, 1'b0, "fair5");

        // Single request from requester 1 (pointer now at 2, scan wraps to 1).
        req_valid = 4'b0010;
        set_op(1, 16'd100, 16'd23);
        run_op(1, 16'd100, 16'd23, 16'd123, 1'b1, "single");

        // Backpressure: requester 3 served, response held 5 cycles, requester 0 waiting.
        set_op(3, 16'h0005, 16'h0007);
        set_op(0, 16'h0100, 16'h0200);
        req_valid = 4'b1001;
        rsp_ready = 1'b0;
        #1;
        chk("bp.grant", 32'(req_ready), 32'h8);
        @(negedge clk);
        chk("bp.start", 32'(add_start), 32'd1);
        req_valid[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp.hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp.hold_id", 32'(rsp_id), 32'd3);
            chk("bp.hold_y", 32'(rsp_y), 32'h000C);
            chk("bp.hold_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        run_op(0, 16'h0100, 16'h0200, 16'h0300, 1'b1, "bp_next");

        // Wrap-around sum with a slower adder.
        adder_lat = 3;
        set_op(2, 16'hFFFF, 16'h0002);
        req_valid = 4'b0100;
        run_op(2, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, "wrap");
        adder_lat = 1;

        // Timeout: silent adder; requester 1 keeps asking, so the next grant proves the pointer moved.
        adder_dead = 1'b1;
        set_op(1, 16'h0AAA, 16'h0001);
        req_valid = 4'b0110;
        #1;
        chk("to.grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        chk("to.start", 32'(add_start), 32'd1);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            chk("to.no_err_yet", 32'(err_to), 32'd0);
            chk("to.no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        chk("to.err_pulse", 32'(err_to), 32'd1);
        chk("to.sticky_late", 32'(err_sticky), 32'd0);
        @(negedge clk);
        chk("to.err_once", 32'(err_to), 32'd0);
        chk("to.sticky", 32'(err_sticky), 32'd1);
        chk("to.no_rsp_after", 32'(rsp_valid), 32'd0);
        #1;
        chk("to.next_grant", 32'(req_ready), 32'h4);

        // Reset in the middle of WAIT for requester 2.
        @(negedge clk);
        chk("rst.start", 32'(add_start), 32'd1);
        chk("rst.add_a", 32'(add_a), 32'hFFFF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        adder_dead = 1'b0;
        set_op(0, 16'h0011, 16'h0022);
        req_valid = 4'b0111;
        chk("rst.no_rsp", 32'(rsp_valid), 32'd0);
        run_op(0, 16'h0011, 16'h0022, 16'h0033, 1'b1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
